// File: rtl/shift_reg_rx.sv
// Serial-to-parallel receiver: collects framed, MSB-first bits into WIDTH-bit words
// and presents them through a one-word valid/ready holding register.
module shift_reg_rx #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_frame,
    output logic [WIDTH-1:0] pout_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             status,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clear_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] pdata_n;
    logic             pvalid_n;
    logic             ovr_n, ferr_n;
    logic             word_done, set_ferr, set_ovr;

    // Both state and the holding register only change on registered edges,
    // so every output is a flop and no input reaches an output combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            pout_data  <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            pout_data  <= pdata_n;
            pout_valid <= pvalid_n;
            overrun    <= ovr_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        word_done = 1'b0;
        set_ferr  = 1'b0;
        if (sin_valid) begin
            case (state)
                IDLE: begin
                    if (sin_frame) begin
                        shreg_n = {{(WIDTH-1){1'b0}}, sin_data};
                        cnt_n   = CW'(1);
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sin_frame) begin
                        // Resync: the new frame bit starts a fresh word.
                        set_ferr = 1'b1;
                        shreg_n  = {{(WIDTH-1){1'b0}}, sin_data};
                        cnt_n    = CW'(1);
                    end else begin
                        shreg_n = {shreg[WIDTH-2:0], sin_data};
                        if (cnt == CW'(WIDTH - 1)) begin
                            word_done = 1'b1;
                            cnt_n     = '0;
                            state_n   = IDLE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Holding register: a finished word may replace one being drained on the same edge.
    always_comb begin
        pdata_n  = pout_data;
        pvalid_n = pout_valid;
        set_ovr  = 1'b0;
        if (word_done) begin
            if (!pout_valid || pout_ready) begin
                pdata_n  = shreg_n;
                pvalid_n = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end else if (pout_valid && pout_ready) begin
            pvalid_n = 1'b0;
        end
    end

    // Sticky flags: a set event wins over a simultaneous clear.
    always_comb begin
        ovr_n  = set_ovr  | (overrun   & ~clear_err);
        ferr_n = set_ferr | (frame_err & ~clear_err);
    end

    assign status = (state == SHIFT);

endmodule

// File: tb/tb_shift_reg_rx.sv
// Directed bench for shift_reg_rx: expected words go to a queue, a monitor
// pops and compares on every handshake; flag/status checks are inline.
module tb_shift_reg_rx;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             sin_frame = 1'b0;
    logic [WIDTH-1:0] pout_data;
    logic             pout_valid;
    logic             pout_ready = 1'b0;
    logic             status;
    logic             overrun;
    logic             frame_err;
    logic             clear_err = 1'b0;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_reg_rx #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_frame(sin_frame),
        .pout_data(pout_data), .pout_valid(pout_valid), .pout_ready(pout_ready),
        .status(status), .overrun(overrun), .frame_err(frame_err),
        .clear_err(clear_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: a word is consumed when valid & ready are seen between edges.
    always @(negedge clock) begin
        if (reset && pout_valid && pout_ready) begin
            if (exp_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL word_unexpected: got 0x%0h expected none at %0t", pout_data, $time);
            end else begin
                chk("word", 32'(pout_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Caller is at posedge+1; returns at the next posedge+1 with the bit taken.
    task automatic send_bit(input logic d, input logic f);
        sin_valid = 1'b1; sin_data = d; sin_frame = f;
        @(posedge clock); #1;
        sin_valid = 1'b0; sin_frame = 1'b0; sin_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gapmax);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i], i == WIDTH - 1);
            if (gapmax > 0 && i > 0) idle($urandom_range(gapmax, 0));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(pout_data),  0);
        chk({tag, "_valid"}, 32'(pout_valid), 0);
        chk({tag, "_status"},32'(status),     0);
        chk({tag, "_ovr"},   32'(overrun),    0);
        chk({tag, "_ferr"},  32'(frame_err),  0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;

        // Reset with random input activity
        repeat (3) begin
            @(posedge clock); #1;
            sin_valid = 1'($urandom); sin_data = 1'($urandom); sin_frame = 1'($urandom);
            pout_ready = 1'($urandom); clear_err = 1'($urandom);
        end
        @(negedge clock);
        chk_all_zero("rst");
        @(posedge clock); #1;
        sin_valid = 0; sin_data = 0; sin_frame = 0; pout_ready = 0; clear_err = 0;
        reset = 1'b1;
        idle(5);
        chk_all_zero("post_rst");

        // Single word, consumer ready
        pout_ready = 1'b1;
        w = 8'hA5;
        exp_q.push_back(w);
        send_bit(w[7], 1'b1);
        chk("a5_status_first", 32'(status), 1);
        for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
        chk("a5_status_last", 32'(status), 0);
        chk("a5_valid", 32'(pout_valid), 1);
        chk("a5_data", 32'(pout_data), 32'h A5);
        idle(1);
        chk("a5_valid_one_cycle", 32'(pout_valid), 0);

        // Gapped word with stray unframed bits first
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("stray_status", 32'(status), 0);
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 4);
        idle(2);
        chk("gap_ovr", 32'(overrun), 0);
        chk("gap_ferr", 32'(frame_err), 0);

        // Backpressure: second word is dropped
        pout_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_word(8'h11, 0);
        send_word(8'h22, 1);
        chk("bp_ovr", 32'(overrun), 1);
        chk("bp_data", 32'(pout_data), 32'h11);
        chk("bp_valid", 32'(pout_valid), 1);
        pout_ready = 1'b1;
        idle(1);
        pout_ready = 1'b0;
        chk("bp_drained", 32'(pout_valid), 0);
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        chk("bp_clear", 32'(overrun), 0);

        // Same-edge drain and fill
        exp_q.push_back(8'h11);
        send_word(8'h11, 0);
        w = 8'h22;
        exp_q.push_back(w);
        send_bit(w[7], 1'b1);
        for (int i = 6; i >= 1; i--) send_bit(w[i], 1'b0);
        pout_ready = 1'b1;
        send_bit(w[0], 1'b0);
        pout_ready = 1'b0;
        chk("df_valid", 32'(pout_valid), 1);
        chk("df_data", 32'(pout_data), 32'h22);
        chk("df_ovr", 32'(overrun), 0);
        pout_ready = 1'b1;
        idle(1);
        chk("df_drained", 32'(pout_valid), 0);

        // Resync after 4 bits, with clear_err on the same edge (set wins)
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        w = 8'h5A;
        exp_q.push_back(w);
        clear_err = 1'b1;
        send_bit(w[7], 1'b1);
        clear_err = 1'b0;
        chk("rs_ferr_set_wins", 32'(frame_err), 1);
        chk("rs_status", 32'(status), 1);
        for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
        chk("rs_data", 32'(pout_data), 32'h5A);
        chk("rs_ferr_sticky", 32'(frame_err), 1);
        idle(1);

        // Asynchronous reset mid-frame, then a clean word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        exp_q.push_back(8'hC3);
        send_word(8'hC3, 0);
        chk("c3_data", 32'(pout_data), 32'hC3);
        idle(3);
        chk("c3_ferr", 32'(frame_err), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
